// File: rtl/light_sequencer_if.sv
// Control/lamp bundle for light_sequencer: requests in, registered lamp drive and status out.
interface light_sequencer_if #(
  parameter int WIDTH = 3
);
  logic             enable;
  logic             dir;
  logic             hazard;
  logic [WIDTH-1:0] lamps;
  logic             busy;
  logic             done;

  modport master (output enable, dir, hazard, input lamps, busy, done);
  modport slave  (input enable, dir, hazard, output lamps, busy, done);
endinterface

// File: rtl/light_sequencer.sv
// Thermometer-fill lamp sweeper with programmable step period, direction and hazard blink.
//
// state   | meaning
// IDLE    | lamps dark, waiting for enable or hazard
// FILL    | k lamps lit, growing one lamp per DIV cycles
// BLANK   | all dark for DIV cycles after the full pattern
// HAZ_ON  | hazard blink, all lamps lit
// HAZ_OFF | hazard blink, all lamps dark
module light_sequencer #(
  parameter int WIDTH = 3,
  parameter int DIV   = 1
) (
  input logic              clk,
  input logic              reset,
  light_sequencer_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int KW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [KW-1:0] K_FULL   = KW'(WIDTH);

  typedef enum logic [2:0] {IDLE, FILL, BLANK, HAZ_ON, HAZ_OFF} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] lamps_q, lamps_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  function automatic logic [WIDTH-1:0] fill_pattern(input logic [KW-1:0] n, input logic down);
    logic [WIDTH-1:0] pat;
    for (int i = 0; i < WIDTH; i++)
      pat[i] = down ? (i >= WIDTH - int'(n)) : (i < int'(n));
    return pat;
  endfunction

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        if (bus.hazard) begin
          state_d = HAZ_ON;
        end else if (bus.enable) begin
          state_d = FILL;
          k_d     = KW'(1);
          dir_d   = bus.dir;
        end
      end
      FILL: begin
        if (bus.hazard) begin
          state_d = HAZ_ON;
          cnt_d   = '0;
        end else if (tick) begin
          if (k_q < K_FULL) k_d = k_q + KW'(1);
          else              state_d = BLANK;
        end
      end
      BLANK: begin
        if (bus.hazard) begin
          state_d = HAZ_ON;
          cnt_d   = '0;
        end else if (tick) begin
          done_d = 1'b1;
          if (bus.enable) begin
            state_d = FILL;
            k_d     = KW'(1);
            dir_d   = bus.dir;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HAZ_ON: begin
        if (!bus.hazard) state_d = IDLE;
        else if (tick)   state_d = HAZ_OFF;
      end
      HAZ_OFF: begin
        if (!bus.hazard) state_d = IDLE;
        else if (tick)   state_d = HAZ_ON;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    case (state_d)
      FILL:    lamps_d = fill_pattern(k_d, dir_d);
      HAZ_ON:  lamps_d = '1;
      default: lamps_d = '0;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      dir_q   <= 1'b0;
      lamps_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      dir_q   <= dir_d;
      lamps_q <= lamps_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.lamps = lamps_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_light_sequencer.sv
// Four configurations driven by shared directed stimulus, checked every cycle against a timing model.
module tb_light_sequencer;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0, dr = 1'b0, hz = 1'b0;

  light_sequencer_if #(.WIDTH(3)) if0 ();
  light_sequencer_if #(.WIDTH(4)) if1 ();
  light_sequencer_if #(.WIDTH(4)) if2 ();
  light_sequencer_if #(.WIDTH(3)) if3 ();

  light_sequencer #(.WIDTH(3), .DIV(1)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  light_sequencer #(.WIDTH(4), .DIV(3)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  light_sequencer #(.WIDTH(4), .DIV(2)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  light_sequencer #(.WIDTH(3), .DIV(2)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));

  always #5 clk = ~clk;

  logic [3:0] act_lamps [N];
  logic       act_busy  [N];
  logic       act_done  [N];
  assign act_lamps[0] = {1'b0, if0.lamps};
  assign act_lamps[1] = if1.lamps;
  assign act_lamps[2] = if2.lamps;
  assign act_lamps[3] = {1'b0, if3.lamps};
  assign act_busy[0] = if0.busy;
  assign act_busy[1] = if1.busy;
  assign act_busy[2] = if2.busy;
  assign act_busy[3] = if3.busy;
  assign act_done[0] = if0.done;
  assign act_done[1] = if1.done;
  assign act_done[2] = if2.done;
  assign act_done[3] = if3.done;

  int w_cfg [N] = '{3, 4, 4, 3};
  int d_cfg [N] = '{1, 3, 2, 2};

  // Model: mode 0 idle, 1 sweeping, 2 hazard; m_t is cycles elapsed since entering the mode.
  int   m_mode [N];
  int   m_t    [N];
  logic m_dir  [N];
  logic m_done [N];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic e, input logic d, input logic h);
    en = e; dr = d; hz = h;
    if0.enable = e; if0.dir = d; if0.hazard = h;
    if1.enable = e; if1.dir = d; if1.hazard = h;
    if2.enable = e; if2.dir = d; if2.hazard = h;
    if3.enable = e; if3.dir = d; if3.hazard = h;
  endtask

  task automatic model_clear(input int i);
    m_mode[i] = 0;
    m_t[i]    = 0;
    m_dir[i]  = 1'b0;
    m_done[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    int sweep_len;
    sweep_len = (w_cfg[i] + 1) * d_cfg[i];
    m_done[i] = 1'b0;
    case (m_mode[i])
      0: begin
        if (hz) begin
          m_mode[i] = 2; m_t[i] = 0;
        end else if (en) begin
          m_mode[i] = 1; m_t[i] = 0; m_dir[i] = dr;
        end
      end
      1: begin
        if (hz) begin
          m_mode[i] = 2; m_t[i] = 0;
        end else if (m_t[i] == sweep_len - 1) begin
          m_done[i] = 1'b1;
          if (en) begin
            m_t[i] = 0; m_dir[i] = dr;
          end else begin
            m_mode[i] = 0;
          end
        end else begin
          m_t[i]++;
        end
      end
      default: begin
        if (!hz) m_mode[i] = 0;
        else     m_t[i]++;
      end
    endcase
  endtask

  function automatic logic [3:0] exp_lamps(input int i);
    int n;
    logic [3:0] ones;
    ones = 4'((1 << w_cfg[i]) - 1);
    case (m_mode[i])
      1: begin
        n = m_t[i] / d_cfg[i] + 1;
        if (n > w_cfg[i]) return 4'd0;
        if (!m_dir[i]) return 4'((1 << n) - 1);
        return 4'(((1 << n) - 1) << (w_cfg[i] - n));
      end
      2: return ((m_t[i] / d_cfg[i]) % 2 == 0) ? ones : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < N; i++) model_clear(i);
    forever begin
      @(posedge clk or negedge reset);
      for (int i = 0; i < N; i++) begin
        if (!reset) model_clear(i);
        else        model_step(i);
      end
      #2;
      for (int i = 0; i < N; i++) begin
        chk($sformatf("u%0d lamps", i), int'(act_lamps[i]), int'(exp_lamps(i)));
        chk($sformatf("u%0d busy", i), int'(act_busy[i]), (m_mode[i] != 0) ? 1 : 0);
        chk($sformatf("u%0d done", i), int'(act_done[i]), int'(m_done[i]));
      end
    end
  end

  int t2_pat [5] = '{8, 12, 14, 15, 0};
  int t3_pat [10] = '{3, 7, 7, 15, 15, 0, 0, 8, 8, 12};
  int t4_pat [6] = '{7, 7, 0, 0, 7, 7};
  int dones, busy_low;

  initial begin
    set_in(0, 0, 0);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset u%0d lamps", i), int'(act_lamps[i]), 0);
      chk($sformatf("reset u%0d busy", i), int'(act_busy[i]), 0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Single sweep, W=3 DIV=1, one-cycle enable
    set_in(1, 0, 0);
    @(negedge clk); chk("t1 c1 lamps", int'(act_lamps[0]), 1); chk("t1 c1 busy", int'(act_busy[0]), 1);
    set_in(0, 0, 0);
    @(negedge clk); chk("t1 c2 lamps", int'(act_lamps[0]), 3);
    @(negedge clk); chk("t1 c3 lamps", int'(act_lamps[0]), 7);
    @(negedge clk); chk("t1 c4 lamps", int'(act_lamps[0]), 0); chk("t1 c4 busy", int'(act_busy[0]), 1);
    chk("t1 c4 done", int'(act_done[0]), 0);
    @(negedge clk); chk("t1 c5 done", int'(act_done[0]), 1); chk("t1 c5 busy", int'(act_busy[0]), 0);
    @(negedge clk); chk("t1 c6 done", int'(act_done[0]), 0);
    repeat (20) @(negedge clk);

    // Continuous downward sweeps, W=4 DIV=3
    set_in(1, 1, 0);
    dones = 0; busy_low = 0;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      chk($sformatf("t2 c%0d lamps", c), int'(act_lamps[1]), t2_pat[((c - 1) % 15) / 3]);
      if (act_done[1]) dones++;
      if (!act_busy[1]) busy_low++;
    end
    chk("t2 done count", dones, 2);
    chk("t2 busy low cycles", busy_low, 0);
    set_in(0, 0, 0);
    repeat (20) @(negedge clk);

    // Direction change mid-sweep, W=4 DIV=2
    set_in(1, 0, 0);
    @(negedge clk); chk("t3 c1 lamps", int'(act_lamps[2]), 1);
    @(negedge clk); chk("t3 c2 lamps", int'(act_lamps[2]), 1);
    @(negedge clk); chk("t3 c3 lamps", int'(act_lamps[2]), 3);
    set_in(1, 1, 0);
    for (int c = 4; c <= 13; c++) begin
      @(negedge clk);
      chk($sformatf("t3 c%0d lamps", c), int'(act_lamps[2]), t3_pat[c - 4]);
    end
    set_in(0, 0, 0);
    repeat (20) @(negedge clk);

    // Hazard while k=2, W=3 DIV=2
    set_in(1, 0, 0);
    @(negedge clk); chk("t4 c1 lamps", int'(act_lamps[3]), 1);
    set_in(0, 0, 0);
    @(negedge clk); chk("t4 c2 lamps", int'(act_lamps[3]), 1);
    @(negedge clk); chk("t4 c3 lamps", int'(act_lamps[3]), 3);
    set_in(0, 0, 1);
    dones = 0;
    for (int c = 4; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("t4 c%0d lamps", c), int'(act_lamps[3]), t4_pat[c - 4]);
      if (act_done[3]) dones++;
    end
    set_in(0, 0, 0);
    @(negedge clk);
    chk("t4 exit lamps", int'(act_lamps[3]), 0);
    chk("t4 exit busy", int'(act_busy[3]), 0);
    if (act_done[3]) dones++;
    chk("t4 done count", dones, 0);
    repeat (20) @(negedge clk);

    // Asynchronous reset mid-fill
    set_in(1, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0);
    @(negedge clk); chk("t5 pre lamps", int'(act_lamps[1]), 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t5 async lamps", int'(act_lamps[1]), 0);
    chk("t5 async busy", int'(act_busy[1]), 0);
    chk("t5 async done", int'(act_done[1]), 0);
    chk("t5 async u0 lamps", int'(act_lamps[0]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5 after busy", int'(act_busy[1]), 0);
    chk("t5 after lamps", int'(act_lamps[1]), 0);

    // Hazard and enable together from IDLE, then enable re-evaluated on exit
    set_in(1, 0, 1);
    @(negedge clk);
    chk("t6 c1 u0 lamps", int'(act_lamps[0]), 7); chk("t6 c1 u0 busy", int'(act_busy[0]), 1);
    chk("t6 c1 u2 lamps", int'(act_lamps[2]), 15);
    @(negedge clk);
    chk("t6 c2 u0 lamps", int'(act_lamps[0]), 0); chk("t6 c2 u2 lamps", int'(act_lamps[2]), 15);
    @(negedge clk);
    chk("t6 c3 u2 lamps", int'(act_lamps[2]), 0);
    set_in(1, 0, 0);
    @(negedge clk);
    chk("t6 exit u2 lamps", int'(act_lamps[2]), 0); chk("t6 exit u2 busy", int'(act_busy[2]), 0);
    @(negedge clk);
    chk("t6 restart u2 lamps", int'(act_lamps[2]), 1); chk("t6 restart u2 busy", int'(act_busy[2]), 1);
    set_in(0, 0, 0);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/light_sequencer.md
# light_sequencer

Parametrised sequential lamp driver for indicator-light arrays. Drives a thermometer-fill sweep across `WIDTH` lamps with a programmable step period, a selectable sweep direction, continuous repeat while `enable` is held, and a hazard (all-lamp blink) override. It generalises the fixed three-lamp, one-step-per-clock turn-signal sequencer and sits between the control inputs and the lamp pins.

## Interface
- `WIDTH`, default 3: number of lamps, ≥ 2.
- `DIV`, default 1: clock cycles per step, ≥ 1. `DIV` = 1 gives one step per clock.

- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-low reset. `reset` = 0 resets immediately, independent of `clk`.
- `enable`  in  1: start a sweep, or keep repeating sweeps while held high.
- `dir`  in  1: sweep direction. 0 lights from `lamps[0]` upward; 1 lights from `lamps[WIDTH-1]` downward.
- `hazard`  in  1: hazard blink request; has priority over the sweep.
- `lamps`  out  WIDTH: registered lamp drive.
- `busy`  out  1: registered; high whenever the state is not IDLE.
- `done`  out  1: registered one-cycle pulse marking the end of a sweep.

## Operation
- States: IDLE, FILL, BLANK, HAZ_ON, HAZ_OFF.
- Internal registers:
  - `cnt`: prescaler, $clog2(DIV) bits, minimum 1 bit.
  - `k`: lit-lamp count, $clog2(WIDTH+1) bits.
  - `dir_q`: latched direction.
- Tick: `tick` = (`cnt` == DIV-1).
  - Outside IDLE, `cnt` increments every cycle and wraps to 0 on `tick`.
  - `cnt` is cleared on every state entry from IDLE and on every entry into HAZ_ON from a non-hazard state.
  - With `DIV` = 1, `tick` is always 1.
- Lamp pattern in FILL:
  - `dir_q` = 0: `lamps` = (1<<k)-1.
  - `dir_q` = 1: the top `k` bits are set.
- IDLE:
  - `lamps` = 0.
  - If `enable` = 1: go to FILL, set `k` = 1, latch `dir_q` = `dir`.
- FILL:
  - On `tick` with `k` < WIDTH: `k` increments.
  - On `tick` with `k` == WIDTH: go to BLANK, `lamps` = 0.
  - Changes on `dir` during a sweep are ignored.
- BLANK: `lamps` = 0. On `tick`:
  - If `enable` = 1: go to FILL, set `k` = 1, re-latch `dir_q`.
  - Otherwise: go to IDLE.
  - In both cases, `done` = 1 for the following cycle only.
- Hazard override:
  - `hazard` = 1 in IDLE, FILL or BLANK: go to HAZ_ON at the next edge, `lamps` = all ones, `cnt` = 0. Any sweep in progress is abandoned and no `done` pulse is generated.
  - HAZ_ON on `tick`: go to HAZ_OFF, `lamps` = 0.
  - HAZ_OFF on `tick`: go to HAZ_ON, `lamps` = all ones.
  - `hazard` = 0 in HAZ_ON or HAZ_OFF: go to IDLE at the next edge, `lamps` = 0. `enable` is re-evaluated from IDLE.
- Simultaneous events:
  - `hazard` beats `enable` and beats `tick`.
  - In BLANK, `tick` with `enable` = 1 restarts without passing through IDLE.
- Reset value of every register: state IDLE, `lamps` = 0, `busy` = 0, `done` = 0, `cnt` = 0, `k` = 0, `dir_q` = 0. Reset mid-sweep or mid-hazard aborts immediately and generates no `done` pulse.

## Timing
- Outputs are registered; there is no combinational path from the inputs to any output.
- Start latency: `enable` sampled high in IDLE at edge E means the first lamp is lit after E.
- Each FILL step lasts DIV cycles; the all-lit step also lasts DIV cycles. BLANK lasts DIV cycles.
- Single sweep: WIDTH·DIV cycles of fill plus DIV cycles of blank.
- Continuous repeat period: (WIDTH+1)·DIV cycles.
- Hazard: entry latency is 1 cycle; half-period is DIV cycles. Exit latency is 1 cycle.
- `busy` rises with the first lit lamp and falls in the same cycle that `lamps` returns to 0 in IDLE.

## Test plan
1. WIDTH=3, DIV=1, `dir`=0, `enable` held high for one cycle. Cycles after the sampling edge: `lamps` = 001, 011, 111, 000. Then IDLE; `done` pulses in cycle 5; `busy` is high for cycles 1–4.
2. WIDTH=4, DIV=3, `dir`=1, `enable` held continuously:
   - `lamps` = 1000, 1100, 1110, 1111, 0000, each for 3 cycles, then 1000 again (no IDLE).
   - `done` pulses once per 15-cycle period.
3. `dir` toggled mid-sweep (WIDTH=4, DIV=2): the current pattern is unchanged. The new direction takes effect only on the next sweep after BLANK.
4. `hazard` raised while `k`=2 (WIDTH=3, DIV=2):
   - Next cycle: `lamps` = 111 for 2 cycles, then 000 for 2 cycles, repeating; no `done` pulse.
   - `hazard` dropped: `lamps` = 000 and IDLE the next cycle.
5. `reset` asserted low asynchronously mid-FILL (between edges): `lamps`, `busy`, `done` go to 0 without a clock edge. After release with `enable`=0, the block stays IDLE.
6. `hazard` and `enable` rise together in IDLE: HAZ_ON is entered and FILL is never entered while `hazard` = 1.
